// File: rtl/transition_pair_sequencer_pkg.sv
// Shared definitions for transition_pair_sequencer: FSM state encoding,
// LFSR seed/tap constants and the parameter legality check.
package transition_pair_sequencer_pkg;

  // Campaign FSM states; the encoding is fixed so traces decode the same way across builds.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11. The design shifts right, which
  // moves those taps to state bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;

  // Legal configuration: at least two vectors, no more than the vector width
  // can express, and a settle window of at least one cycle.
  function automatic bit params_legal(input int in_w, input int limit, input int settle);
    return (in_w >= 1) && (limit >= 2) && (limit <= (1 << in_w)) && (settle >= 1);
  endfunction

endpackage

// File: rtl/transition_pair_sequencer_mask_lfsr.sv
// mask_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying fresh mask
// randomness. Load wins over step. A zero seed is replaced by the default
// seed, so the all-zero lock-up state can never be entered.
module mask_lfsr
  import transition_pair_sequencer_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_step,
  output logic [15:0] o_state
);

  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? LFSR_SEED_DEFAULT : SEED;

  logic [15:0] r_state;
  logic        w_feedback;

  assign w_feedback = ^(r_state & LFSR_TAPS);

  // Seed on reset or load, otherwise shift right with feedback into bit 15.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SEED_SAFE;
    end else if (i_load) begin
      r_state <= SEED_SAFE;
    end else if (i_step) begin
      r_state <= {w_feedback, r_state[15:1]};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/transition_pair_sequencer.sv
// transition_pair_sequencer: walks every ordered pair (i, j) of input vectors.
// It drives i for SETTLE cycles and then j for at least SETTLE cycles, and
// frames each transition with trace_begin/trace_end. Optional feature macro:
// TRANSITION_PAIR_MASK_LFSR_EN adds a per-phase random mask output (mask_out).
// sim_idx ends at LIMIT*LIMIT (or LIMIT*(LIMIT-1) with skip_self). Give it
// enough CNT_W bits to hold that count, or it wraps.
module transition_pair_sequencer
  import transition_pair_sequencer_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int LIMIT  = 2**IN_W,
  parameter int SETTLE = 5,
  parameter int CNT_W  = 2*IN_W
`ifdef TRANSITION_PAIR_MASK_LFSR_EN
  ,
  parameter int          R_W       = 2,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             skip_self,
  input  logic             capture_ready,
  output logic [IN_W-1:0]  vec_out,
  output logic             phase,
  output logic             trace_begin,
  output logic             trace_end,
  output logic [CNT_W-1:0] sim_idx,
  output logic             busy,
  output logic             done
`ifdef TRANSITION_PAIR_MASK_LFSR_EN
  ,
  output logic [R_W-1:0]   mask_out
`endif
);

  if (!params_legal(IN_W, LIMIT, SETTLE)) begin : g_param_check
    $error("transition_pair_sequencer: illegal IN_W/LIMIT/SETTLE combination");
  end

  // One extra bit lets j+2 and i+1 overflow past LIMIT without wrapping.
  localparam int             IW1 = IN_W + 1;
  localparam int             SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IW1-1:0] LIM = IW1'(LIMIT);
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE - 1);

  state_t            r_state, w_state_nxt;
  logic [IN_W-1:0]   r_i, r_j, w_i_nxt, w_j_nxt;
  logic [SW-1:0]     r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]  r_sim_idx, w_sim_idx_nxt;
  logic              r_skip, w_skip_nxt;
  logic              r_done, w_done_nxt;

  logic [IW1-1:0]    w_j_step, w_i_step;
  logic [IN_W-1:0]   w_pair_i, w_pair_j;
  logic              w_last_pair;
  logic              w_settled;

  assign w_settled = (r_cnt == SETTLE_LAST);

  // Successor of the current pair: j inner, i outer, self-pairs skipped at zero cost.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave a latch.
    w_i_step = {1'b0, r_i};
    w_j_step = {1'b0, r_j} + IW1'(1);
    if (r_skip && (w_j_step == w_i_step)) begin
      w_j_step = w_j_step + IW1'(1);
    end
    if (w_j_step >= LIM) begin
      w_i_step = w_i_step + IW1'(1);
      w_j_step = (r_skip && (w_i_step == '0)) ? IW1'(1) : '0;
    end
    w_last_pair = (w_i_step >= LIM);
    w_pair_i    = w_i_step[IN_W-1:0];
    w_pair_j    = w_j_step[IN_W-1:0];
  end

  // Next state, datapath updates and phase outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_i_nxt       = r_i;
    w_j_nxt       = r_j;
    w_cnt_nxt     = r_cnt;
    w_sim_idx_nxt = r_sim_idx;
    w_skip_nxt    = r_skip;
    w_done_nxt    = 1'b0;
    vec_out       = '0;
    phase         = 1'b0;
    trace_begin   = 1'b0;
    trace_end     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_state_nxt   = ST_INIT;
          w_i_nxt       = '0;
          w_j_nxt       = IN_W'(skip_self);
          w_cnt_nxt     = '0;
          w_sim_idx_nxt = '0;
          w_skip_nxt    = skip_self;
        end
      end
      ST_INIT: begin
        vec_out = r_i;
        if (w_settled) begin
          w_state_nxt = ST_FINAL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + SW'(1);
        end
      end
      ST_FINAL: begin
        vec_out     = r_j;
        phase       = 1'b1;
        trace_begin = (r_cnt == '0);
        if (!w_settled) begin
          w_cnt_nxt = r_cnt + SW'(1);
        end else if (capture_ready) begin
          trace_end     = 1'b1;
          w_sim_idx_nxt = r_sim_idx + CNT_W'(1);
          w_cnt_nxt     = '0;
          if (w_last_pair) begin
            w_state_nxt = ST_IDLE;
            w_i_nxt     = '0;
            w_j_nxt     = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_INIT;
            w_i_nxt     = w_pair_i;
            w_j_nxt     = w_pair_j;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abort beats completion: the pair in flight is dropped without a trace_end.
    if ((r_state != ST_IDLE) && abort) begin
      w_state_nxt   = ST_IDLE;
      w_i_nxt       = '0;
      w_j_nxt       = '0;
      w_cnt_nxt     = '0;
      w_sim_idx_nxt = '0;
      w_done_nxt    = 1'b0;
      trace_end     = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_cnt     <= '0;
      r_sim_idx <= '0;
      r_skip    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_i       <= w_i_nxt;
      r_j       <= w_j_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sim_idx <= w_sim_idx_nxt;
      r_skip    <= w_skip_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign sim_idx = r_sim_idx;

`ifdef TRANSITION_PAIR_MASK_LFSR_EN
  logic        w_lfsr_load;
  logic        w_lfsr_step;
  logic [15:0] w_lfsr_state;

  // Reseed on an accepted start. Step during the first cycle of each INIT and FINAL phase.
  assign w_lfsr_load = (r_state == ST_IDLE) && start && !abort;
  assign w_lfsr_step = ((r_state == ST_INIT) || (r_state == ST_FINAL)) && (r_cnt == '0);

  mask_lfsr #(
    .SEED (LFSR_SEED)
  ) u_mask_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_lfsr_load),
    .i_step  (w_lfsr_step),
    .o_state (w_lfsr_state)
  );

  assign mask_out = w_lfsr_state[R_W-1:0];
`endif

endmodule

// File: tb/tb_transition_pair_sequencer.sv
// Self-checking bench for transition_pair_sequencer (IN_W=2, LIMIT=4, SETTLE=3).
// The reference is a list of expected pairs built by nested loops, plus the
// phase timing rules applied per cycle. Stalls, stray starts and skip_self
// toggles are drawn from $urandom.
module tb_transition_pair_sequencer;

  localparam int IN_W   = 2;
  localparam int LIMIT  = 4;
  localparam int SETTLE = 3;
  localparam int CNT_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             skip_self = 1'b0;
  logic             capture_ready = 1'b0;
  logic [IN_W-1:0]  vec_out;
  logic             phase;
  logic             trace_begin;
  logic             trace_end;
  logic [CNT_W-1:0] sim_idx;
  logic             busy;
  logic             done;

`ifdef TRANSITION_PAIR_MASK_LFSR_EN
  localparam int          R_W  = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  logic [R_W-1:0] mask_out;
  logic [15:0]    lfsr_m = SEED;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  transition_pair_sequencer #(
    .IN_W   (IN_W),
    .LIMIT  (LIMIT),
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
`ifdef TRANSITION_PAIR_MASK_LFSR_EN
    ,
    .R_W       (R_W),
    .LFSR_SEED (SEED)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .skip_self     (skip_self),
    .capture_ready (capture_ready),
    .vec_out       (vec_out),
    .phase         (phase),
    .trace_begin   (trace_begin),
    .trace_end     (trace_end),
    .sim_idx       (sim_idx),
    .busy          (busy),
    .done          (done)
`ifdef TRANSITION_PAIR_MASK_LFSR_EN
    ,
    .mask_out      (mask_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int idx, input bit exp_done);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_vec"},   vec_out, 0);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_tb"},    trace_begin, 0);
    check({tag, "_te"},    trace_end, 0);
    check({tag, "_idx"},   sim_idx, idx);
    check({tag, "_done"},  done, exp_done);
`ifdef TRANSITION_PAIR_MASK_LFSR_EN
    check({tag, "_mask"},  mask_out, lfsr_m[R_W-1:0]);
`endif
  endtask

  // One campaign from start to done, or until an abort/reset is injected.
  // stall_pair/stall_len force capture_ready low after the settle window of
  // one pair. abort_pair asserts abort in INIT; reset_pair pulls rst_n in FINAL.
  task automatic run_campaign(input bit skip, input bit rand_mode, input int stall_pair,
                              input int stall_len, input int abort_pair, input int reset_pair);
    int  pi[$];
    int  pj[$];
    int  stall;
    int  last_c;
    bit  stop;
    for (int i = 0; i < LIMIT; i++) begin
      for (int j = 0; j < LIMIT; j++) begin
        if (!(skip && (i == j))) begin
          pi.push_back(i);
          pj.push_back(j);
        end
      end
    end

    next_cycle();
    start = 1'b1;
    skip_self = skip;
    abort = 1'b0;
    capture_ready = 1'b0;
`ifdef TRANSITION_PAIR_MASK_LFSR_EN
    lfsr_m = SEED;
`endif
    stop = 1'b0;

    for (int p = 0; (p < pi.size()) && !stop; p++) begin
      for (int c = 0; (c < SETTLE) && !stop; c++) begin
        next_cycle();
        start         = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        skip_self     = rand_mode ? 1'($urandom_range(0, 1)) : skip;
        capture_ready = 1'($urandom_range(0, 1));
        abort         = (p == abort_pair) && (c == 1);
        #1;
        check("init_vec",   vec_out, pi[p]);
        check("init_phase", phase, 0);
        check("init_busy",  busy, 1);
        check("init_idx",   sim_idx, p);
        check("init_tb",    trace_begin, 0);
        check("init_te",    trace_end, 0);
        check("init_done",  done, 0);
`ifdef TRANSITION_PAIR_MASK_LFSR_EN
        check("init_mask", mask_out, lfsr_m[R_W-1:0]);
        if (c == 0) lfsr_m = lfsr_next(lfsr_m);
`endif
        if (abort) begin
          next_cycle();
          abort = 1'b0;
          start = 1'b0;
          capture_ready = 1'b0;
          #1;
          check_idle("abort", 0, 0);
          stop = 1'b1;
        end
      end

      if (!stop) begin
        stall  = (p == stall_pair) ? stall_len : (rand_mode ? $urandom_range(0, 2) : 0);
        last_c = SETTLE - 1 + stall;
        for (int c = 0; (c <= last_c) && !stop; c++) begin
          next_cycle();
          start     = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
          skip_self = rand_mode ? 1'($urandom_range(0, 1)) : skip;
          // Before the settle window ends capture_ready must be ignored, so it is random there.
          capture_ready = (c < SETTLE - 1) ? 1'($urandom_range(0, 1)) : (c == last_c);
          if ((p == reset_pair) && (c == 1)) rst_n = 1'b0;
          #1;
          check("final_vec",   vec_out, pj[p]);
          check("final_phase", phase, 1);
          check("final_busy",  busy, 1);
          check("final_idx",   sim_idx, p);
          check("final_tb",    trace_begin, (c == 0));
          check("final_te",    trace_end, (c == last_c));
          check("final_done",  done, 0);
`ifdef TRANSITION_PAIR_MASK_LFSR_EN
          check("final_mask", mask_out, lfsr_m[R_W-1:0]);
          if (c == 0) lfsr_m = lfsr_next(lfsr_m);
`endif
          if (!rst_n) begin
            next_cycle();
            rst_n = 1'b1;
            start = 1'b0;
            capture_ready = 1'b0;
`ifdef TRANSITION_PAIR_MASK_LFSR_EN
            lfsr_m = SEED;
`endif
            #1;
            check_idle("midreset", 0, 0);
            stop = 1'b1;
          end
        end
      end
    end

    if (!stop) begin
      next_cycle();
      start = 1'b0;
      capture_ready = 1'b0;
      #1;
      check_idle("done", pi.size(), 1);
      next_cycle();
      #1;
      check_idle("after_done", pi.size(), 0);
    end else begin
      next_cycle();
      #1;
      check("no_done_after_stop", done, 0);
      check("idle_after_stop", busy, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    check_idle("reset", 0, 0);
    rst_n = 1'b1;

    // Full 16-pair walk; done lands 97 cycles after the start cycle.
    run_campaign(1'b0, 1'b0, -1, 0, -1, -1);
    // Self-pairs skipped: 12 pairs starting at (0,1).
    run_campaign(1'b1, 1'b0, -1, 0, -1, -1);
    // Capture backpressure: four extra cycles held at the end of pair 2.
    run_campaign(1'b0, 1'b0, 2, 4, -1, -1);
    // Abort during INIT of pair 5, then a fresh randomized run from (0,0).
    run_campaign(1'b0, 1'b1, -1, 0, 5, -1);
    run_campaign(1'b0, 1'b1, -1, 0, -1, -1);

    // start and abort together in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    next_cycle();
    start = 1'b0;
    abort = 1'b0;
    #1;
    check_idle("start_abort", LIMIT * LIMIT, 0);

    // Reset mid-FINAL of pair 7, then a fresh randomized skip_self campaign.
    run_campaign(1'b0, 1'b1, -1, 0, -1, 7);
    run_campaign(1'b1, 1'b1, -1, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
